// File: rtl/counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | counter_ctrl : command queue + sequencer driving a 4-bit up/down counter|
// | Optional wrap guard: define CNT_CTRL_WRAP_STOP_EN.   Revision: 1.0      |
// +------------------------------------------------------------------------+
module counter_ctrl #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_start,
   input  logic             cmd_dir,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             abort,
   input  logic [3:0]       cnt_q,
   output logic             cnt_load,
   output logic [3:0]       cnt_data,
   output logic             cnt_updown,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             wrap_stop
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0]       start;
      logic             dir;
      logic [LEN_W-1:0] len;
   } cmd_t;

   state_t           state_q, state_d;
   cmd_t             fifo_q [0:1];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       count_q;
   cmd_t             cur_q, cur_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             done_q, aborted_q;

   cmd_t w_cmd_in;
   logic w_empty, w_full, w_push_req, w_push, w_pop, w_bypass, w_end_abort;

   assign w_cmd_in   = {cmd_start, cmd_dir, cmd_len};
   assign w_empty    = (count_q == 2'd0);
   assign w_full     = (count_q == 2'd2);
   assign cmd_ready  = !w_full;
   assign w_push_req = cmd_valid && cmd_ready;
   // A command arriving at an idle controller with an empty queue goes straight to LOAD.
   assign w_push     = w_push_req && !w_bypass;

`ifdef CNT_CTRL_WRAP_STOP_EN
   logic w_end_wrap;
   logic wrap_q;
   assign wrap_stop = wrap_q;
`else
   assign wrap_stop = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rem_d       = rem_q;
      cnt_load    = 1'b1;
      cnt_data    = cnt_q;
      cnt_updown  = 1'b0;
      busy        = 1'b0;
      w_pop       = 1'b0;
      w_bypass    = 1'b0;
      w_end_abort = 1'b0;
`ifdef CNT_CTRL_WRAP_STOP_EN
      w_end_wrap  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop   = 1'b1;
               cur_d   = fifo_q[rd_ptr_q];
               state_d = S_LOAD;
            end else if (w_push_req) begin
               w_bypass = 1'b1;
               cur_d    = w_cmd_in;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy       = 1'b1;
            cnt_updown = cur_q.dir;
            if (abort) begin
               w_end_abort = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_data = cur_q.start;
               rem_d    = cur_q.len;
               state_d  = (cur_q.len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            busy       = 1'b1;
            cnt_updown = cur_q.dir;
            if (abort) begin
               w_end_abort = 1'b1;
               state_d     = S_DONE;
`ifdef CNT_CTRL_WRAP_STOP_EN
            end else if ((cur_q.dir && cnt_q == 4'd15) || (!cur_q.dir && cnt_q == 4'd0)) begin
               w_end_wrap = 1'b1;
               state_d    = S_DONE;
`endif
            end else begin
               cnt_load = 1'b0;
               rem_d    = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!w_empty) begin
               w_pop   = 1'b1;
               cur_d   = fifo_q[rd_ptr_q];
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         cur_q     <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         rem_q     <= rem_d;
         done_q    <= (state_d == S_DONE);
         aborted_q <= w_end_abort;
         if (w_push) begin
            fifo_q[wr_ptr_q] <= w_cmd_in;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(w_push) - 2'(w_pop);
      end
   end

`ifdef CNT_CTRL_WRAP_STOP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= w_end_wrap;
      end
   end
`endif

   assign done    = done_q;
   assign aborted = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_counter_ctrl : random + directed bench for counter_ctrl with a       |
// | timeline model of command execution.                 Revision: 1.0      |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_counter_ctrl;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_start = 4'd0;
   logic             cmd_dir = 1'b0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             abort = 1'b0;
   logic [3:0]       cnt = 4'd0;
   logic             cnt_load;
   logic [3:0]       cnt_data;
   logic             cnt_updown;
   logic             busy, done, aborted, wrap_stop;

   counter_ctrl #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
      .abort(abort), .cnt_q(cnt),
      .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_updown(cnt_updown),
      .busy(busy), .done(done), .aborted(aborted), .wrap_stop(wrap_stop)
   );

   always #5 clk = ~clk;

   // The 4-bit up/down counter being controlled (no enable).
   always @(posedge clk) cnt <= cnt_load ? cnt_data : (cnt_updown ? cnt + 4'd1 : cnt - 4'd1);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Timeline model: each command occupies LOAD at cycle L and finishes at D = L+len+1,
   // unless an abort (or the wrap guard) pulls D in.
   typedef struct {logic [3:0] s; logic d; int l;} mcmd_t;
   typedef struct {int c; logic [3:0] v; logic ab; logic wr;} dn_t;
   mcmd_t      mq[$];
   dn_t        obs[$];
   bit         act = 0;
   int         mL = 0, mD = 0;
   mcmd_t      cur;
   bit         mab = 0, mwr = 0;
   logic [3:0] cval = 4'd0;
   bit         chk_en = 0;

   task automatic model_reset();
      mq.delete();
      act = 0;
   endtask

   task automatic begin_cmd(input mcmd_t c);
      act = 1; cur = c; mL = cyc + 1; mD = mL + c.l + 1; mab = 0; mwr = 0;
   endtask

   always @(negedge clk) begin
      bit in_win, is_done, acc, used;
      mcmd_t inc;
      if (chk_en && rst) begin
         in_win  = act && (cyc < mD);
         is_done = act && (cyc == mD);
         chk("busy", busy, in_win);
         chk("done", done, is_done);
         chk("aborted", aborted, is_done && mab);
         chk("wrap_stop", wrap_stop, is_done && mwr);
         chk("cmd_ready", cmd_ready, mq.size() < 2);
         chk("cnt_q", cnt, cval);
         if (!in_win) chk("hold", cnt_load && (cnt_data == cnt), 1);
         if (done) obs.push_back('{cyc, cnt, aborted, wrap_stop});

         acc  = cmd_valid && (mq.size() < 2);
         inc  = '{cmd_start, cmd_dir, int'(cmd_len)};
         used = 0;
         if (in_win) begin
            if (abort) begin
               mD = cyc + 1; mab = 1;
            end else if (cyc == mL) begin
               cval = cur.s;
`ifdef CNT_CTRL_WRAP_STOP_EN
            end else if ((cur.d && cval == 4'd15) || (!cur.d && cval == 4'd0)) begin
               mD = cyc + 1; mwr = 1;
`endif
            end else begin
               cval = cur.d ? cval + 4'd1 : cval - 4'd1;
            end
         end
         if (!act || is_done) begin
            if (mq.size() > 0) begin
               begin_cmd(mq.pop_front());
            end else if (!act && acc) begin
               begin_cmd(inc);
               used = 1;
            end else begin
               act = 0;
            end
         end
         if (acc && !used) mq.push_back(inc);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [3:0] s, input logic d, input int l, output int ac, output int waited);
      cmd_valid = 1; cmd_start = s; cmd_dir = d; cmd_len = LEN_W'(l);
      ac = -1; waited = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (cmd_ready) ac = cyc; else waited++;
         @(posedge clk); #1;
         if (ac >= 0) break;
      end
      cmd_valid = 0;
      if (ac < 0) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_obs(input int n);
      for (int i = 0; i < 2000 && obs.size() < n; i++) tick();
      if (obs.size() < n) chk("done_timeout", obs.size(), n);
   endtask

   function automatic dn_t ob(input int i);
      if (i < obs.size()) return obs[i];
      return '{-1, 4'd0, 1'b0, 1'b0};
   endfunction

   int a, a2, w;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_wrap", wrap_stop, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_load", cnt_load, 1);
      chk("rst_data", cnt_data, cnt);
      chk("rst_updown", cnt_updown, 0);
      rst = 1; model_reset(); chk_en = 1;
      tick(2);

      // Basic run: 7 up 5 -> 12, done 7 cycles after acceptance.
      obs.delete();
      send(4'd7, 1'b1, 5, a, w);
      wait_obs(1);
      chk("t1_latency", ob(0).c - a, 7);
      chk("t1_value", ob(0).v, 12);
      chk("t1_aborted", ob(0).ab, 0);
      tick(2);

      // Wrap from 15 upward.
      obs.delete();
      send(4'd15, 1'b1, 3, a, w);
      wait_obs(1);
`ifdef CNT_CTRL_WRAP_STOP_EN
      chk("t2_value", ob(0).v, 15);
      chk("t2_wrap", ob(0).wr, 1);
      chk("t2_latency", ob(0).c - a, 3);
`else
      chk("t2_value", ob(0).v, 2);
      chk("t2_wrap", ob(0).wr, 0);
      chk("t2_latency", ob(0).c - a, 5);
`endif
      tick(2);

      // Back-to-back commands, second has len=0.
      obs.delete();
      send(4'd0, 1'b0, 1, a, w);
      send(4'd4, 1'b1, 0, a2, w);
      wait_obs(2);
`ifdef CNT_CTRL_WRAP_STOP_EN
      chk("t3_first", ob(0).v, 0);
`else
      chk("t3_first", ob(0).v, 15);
`endif
      chk("t3_second", ob(1).v, 4);
      chk("t3_gap", ob(1).c - ob(0).c, 2);
      tick(2);

      // Back-pressure with a full queue; completions in order.
      obs.delete();
      send(4'd1, 1'b1, 6, a, w);
      send(4'd2, 1'b1, 1, a, w);
      send(4'd5, 1'b0, 2, a, w);
      send(4'd9, 1'b1, 0, a, w);
      chk("t4_backpressure", w, 6);
      wait_obs(4);
      chk("t4_v0", ob(0).v, 7);
      chk("t4_v1", ob(1).v, 3);
      chk("t4_v2", ob(2).v, 3);
      chk("t4_v3", ob(3).v, 9);
      tick(2);

      // Abort on the 4th RUN cycle.
      obs.delete();
      send(4'd3, 1'b1, 10, a, w);
      tick(4);
      abort = 1; tick(); abort = 0;
      wait_obs(1);
      chk("t5_value", ob(0).v, 6);
      chk("t5_aborted", ob(0).ab, 1);
      chk("t5_latency", ob(0).c - a, 6);
      tick(3);
      chk("t5_hold", cnt, 6);

      // Reset in the middle of RUN, with a command queued behind.
      obs.delete();
      send(4'd2, 1'b0, 20, a, w);
      send(4'd8, 1'b1, 3, a, w);
      tick(3);
      rst = 0; chk_en = 0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_ready", cmd_ready, 1);
      tick(2);
      rst = 1; model_reset(); chk_en = 1;
      tick(6);
      chk("t6_no_done", obs.size(), 0);

      // Longest run, counting down.
      obs.delete();
      send(4'd5, 1'b0, 255, a, w);
      wait_obs(1);
`ifdef CNT_CTRL_WRAP_STOP_EN
      chk("t7_value", ob(0).v, 0);
`else
      chk("t7_value", ob(0).v, 6);
      chk("t7_latency", ob(0).c - a, 257);
`endif
      tick(2);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         cmd_valid = ($urandom % 3) == 0;
         cmd_start = 4'($urandom);
         cmd_dir   = 1'($urandom);
         cmd_len   = LEN_W'((($urandom % 8) == 0) ? $urandom % 40 : $urandom % 6);
         abort     = ($urandom % 20) == 0;
         tick();
      end
      cmd_valid = 0; abort = 0;
      tick(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
